// File: rtl/mq_byteout_buf.sv
// MQ coder byte-output stage: BYTEOUT with 0xFF stuffing and carry into the held byte B,
// the FLUSH sequence, and an output FIFO of {byte, address} pairs.
module mq_byteout_buf #(
    parameter int FIFO_DEPTH = 4,
    parameter int BP_W       = 16,
    parameter int BP_START   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bo_req,
    input  logic            flush_req,
    output logic            req_ready,
    input  logic [27:0]     c_in,
    input  logic [15:0]     a_in,
    input  logic [3:0]      ct_in,
    output logic [27:0]     c_out,
    output logic [3:0]      ct_out,
    output logic            bo_done,
    output logic            flush_done,
    output logic [7:0]      out_data,
    output logic [BP_W-1:0] out_bp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BP_W-1:0] byte_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 8 + BP_W;
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_M2 = (AW+1)'(FIFO_DEPTH - 2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SETB = 3'd1;
    localparam logic [2:0] S_FL1  = 3'd2;
    localparam logic [2:0] S_FL2  = 3'd3;
    localparam logic [2:0] S_LAST = 3'd4;

    typedef struct packed {
        logic [7:0]  ebyte;
        logic [7:0]  nb;
        logic [27:0] nc;
        logic [3:0]  nct;
    } bo_t;

    function automatic bo_t byteout(input logic [7:0] b, input logic [27:0] c);
        bo_t        r;
        logic [7:0] b1;
        b1 = b + 8'd1;
        if (b == 8'hFF) begin
            r.ebyte = 8'hFF;
            r.nb    = {1'b0, c[26:20]};
            r.nc    = c & 28'h00FFFFF;
            r.nct   = 4'd7;
        end else if (!c[27]) begin
            r.ebyte = b;
            r.nb    = c[26:19];
            r.nc    = c & 28'h007FFFF;
            r.nct   = 4'd8;
        end else if (b1 == 8'hFF) begin
            // carry made B 0xFF: bit 27 is consumed by the carry, then stuff
            r.ebyte = 8'hFF;
            r.nb    = {1'b0, c[26:20]};
            r.nc    = c & 28'h00FFFFF;
            r.nct   = 4'd7;
        end else begin
            r.ebyte = b1;
            r.nb    = c[26:19];
            r.nc    = c & 28'h007FFFF;
            r.nct   = 4'd8;
        end
        return r;
    endfunction

    function automatic logic [27:0] setbits(input logic [27:0] c, input logic [15:0] a,
                                            input logic [3:0] ct);
        logic [27:0] t;
        logic [27:0] cs;
        t  = c + {12'h000, a};
        cs = c | 28'h000FFFF;
        if (cs >= t) cs = cs - 28'h0008000;
        return cs << ct;
    endfunction

    logic [2:0]      state;
    logic [27:0]     c_reg;
    logic [15:0]     a_reg;
    logic [3:0]      ct_reg;
    logic [7:0]      b_reg;
    logic            first;
    logic [BP_W-1:0] bp;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [EW-1:0]   head;
    logic            idle, pop, push, stall, push_space, free_ge1, free_ge2;
    logic            accept_bo, accept_fl, emit_try;
    logic [7:0]      emit_byte;
    logic [27:0]     bo_src;
    bo_t             bo_res;

    assign idle       = (state == S_IDLE);
    assign out_valid  = (count != '0);
    assign head       = mem[rd_ptr];
    assign out_data   = out_valid ? head[EW-1:BP_W] : 8'h00;
    assign out_bp     = out_valid ? head[BP_W-1:0] : '0;
    assign pop        = out_valid && out_ready;
    assign free_ge1   = (count < DEPTH_C);
    assign free_ge2   = (count <= DEPTH_M2);
    assign push_space = free_ge1 || pop;
    assign accept_bo  = idle && bo_req && free_ge1;
    assign accept_fl  = idle && flush_req && !bo_req && free_ge2;
    assign req_ready  = idle && free_ge1 && (bo_req || !flush_req || free_ge2);

    always_comb begin
        bo_src    = idle ? c_in : c_reg;
        bo_res    = byteout(b_reg, bo_src);
        emit_try  = 1'b0;
        emit_byte = bo_res.ebyte;
        case (state)
            S_IDLE:        emit_try = accept_bo;
            S_FL1, S_FL2:  emit_try = 1'b1;
            S_LAST: begin
                emit_try  = (b_reg != 8'hFF);
                emit_byte = b_reg;
            end
            default: ;
        endcase
        // while first is set the byte is the dummy in front of the codeblock
        push  = emit_try && !first && push_space;
        stall = emit_try && !first && !push_space;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            b_reg      <= 8'h00;
            first      <= 1'b1;
            bp         <= BP_W'(BP_START);
            byte_count <= '0;
            c_out      <= '0;
            ct_out     <= '0;
            bo_done    <= 1'b0;
            flush_done <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            bo_done    <= 1'b0;
            flush_done <= 1'b0;
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                bp         <= bp + 1'b1;
                byte_count <= byte_count + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case (state)
                S_IDLE: begin
                    if (accept_bo) begin
                        b_reg   <= bo_res.nb;
                        c_out   <= bo_res.nc;
                        ct_out  <= bo_res.nct;
                        bo_done <= 1'b1;
                        first   <= 1'b0;
                    end else if (accept_fl) begin
                        state <= S_SETB;
                    end
                end
                S_SETB: state <= S_FL1;
                S_FL1, S_FL2: begin
                    if (!stall) begin
                        b_reg <= bo_res.nb;
                        first <= 1'b0;
                        state <= (state == S_FL1) ? S_FL2 : S_LAST;
                    end
                end
                S_LAST: begin
                    if (!stall) begin
                        // next codeblock starts like a fresh reset: B=0 behind a dummy byte
                        b_reg      <= 8'h00;
                        first      <= 1'b1;
                        flush_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {emit_byte, bp};
        case (state)
            S_IDLE: begin
                if (accept_fl) begin
                    c_reg  <= c_in;
                    a_reg  <= a_in;
                    ct_reg <= ct_in;
                end
            end
            S_SETB:       c_reg <= setbits(c_reg, a_reg, ct_reg);
            S_FL1, S_FL2: if (!stall) c_reg <= bo_res.nc << bo_res.nct;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mq_byteout_buf.sv
// Bench for mq_byteout_buf: directed vector table, hand-built flush/backpressure/reset
// sequences, and random traffic against an arithmetic reference model with a byte scoreboard.
module tb_mq_byteout_buf;
    localparam int DEPTH = 4;
    localparam int BPW   = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           bo_req = 1'b0, flush_req = 1'b0, out_ready;
    logic [27:0]    c_in = '0;
    logic [15:0]    a_in = '0;
    logic [3:0]     ct_in = '0;
    logic           req_ready, bo_done, flush_done, out_valid;
    logic [27:0]    c_out;
    logic [3:0]     ct_out;
    logic [7:0]     out_data;
    logic [BPW-1:0] out_bp, byte_count;

    mq_byteout_buf #(.FIFO_DEPTH(DEPTH), .BP_W(BPW), .BP_START(0)) dut (
        .clk(clk), .rst(rst), .bo_req(bo_req), .flush_req(flush_req), .req_ready(req_ready),
        .c_in(c_in), .a_in(a_in), .ct_in(ct_in), .c_out(c_out), .ct_out(ct_out),
        .bo_done(bo_done), .flush_done(flush_done), .out_data(out_data), .out_bp(out_bp),
        .out_valid(out_valid), .out_ready(out_ready), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ready_mode = 1;

    typedef struct { int byte_v; int bp; } exp_t;
    exp_t exp_q[$];
    int   m_b = 0;
    bit   m_first = 1'b1;
    int   m_bp = 0;
    int   m_cnt = 0;

    typedef struct { longint c; int emit; longint ec; int ect; } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_emit(input int v);
        exp_t e;
        if (m_first) begin
            m_first = 1'b0;
        end else begin
            e.byte_v = v;
            e.bp     = m_bp;
            exp_q.push_back(e);
            m_bp  = (m_bp + 1) % 65536;
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic m_byteout(input longint cin, output longint cout, output int ct);
        longint c = cin;
        if (m_b == 255) begin
            m_emit(255);
            m_b = int'((c / (64'd1 << 20)) % 128);
            c = c % (64'd1 << 20);
            ct = 7;
        end else if (c < (64'd1 << 27)) begin
            m_emit(m_b);
            m_b = int'((c / (64'd1 << 19)) % 256);
            c = c % (64'd1 << 19);
            ct = 8;
        end else begin
            m_b = m_b + 1;
            if (m_b == 255) begin
                c = c % (64'd1 << 27);
                m_emit(255);
                m_b = int'((c / (64'd1 << 20)) % 128);
                c = c % (64'd1 << 20);
                ct = 7;
            end else begin
                m_emit(m_b);
                m_b = int'((c / (64'd1 << 19)) % 256);
                c = c % (64'd1 << 19);
                ct = 8;
            end
        end
        cout = c;
    endtask

    task automatic m_flush(input longint cin, input longint a, input int ct);
        longint c, t;
        int     k;
        c = cin;
        t = (c + a) % (64'd1 << 28);
        c = c | 64'hFFFF;
        if (c >= t) c = c - 32768;
        c = (c * (64'd1 << ct)) % (64'd1 << 28);
        for (int r = 0; r < 2; r++) begin
            m_byteout(c, c, k);
            c = (c * (64'd1 << k)) % (64'd1 << 28);
        end
        if (m_b != 255) m_emit(m_b);
        m_first = 1'b1;
        m_b = 0;
    endtask

    // Called at posedge+1; returns at the negedge before the accepting edge.
    task automatic bo_start(input logic [27:0] c, output bit ok);
        bo_req = 1'b1;
        c_in = c;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL bo_accept: req_ready never seen, c_in=0x%0h", c);
            bo_req = 1'b0;
            flush_req = 1'b0;
        end
    endtask

    task automatic bo_finish(input longint ec, input int ect);
        @(posedge clk); #1;
        bo_req = 1'b0;
        flush_req = 1'b0;
        chk("bo_done", bo_done, 1);
        chk("c_out", c_out, ec);
        chk("ct_out", ct_out, ect);
        chk("byte_count", byte_count, m_cnt % 65536);
    endtask

    task automatic bo_model(input logic [27:0] c);
        bit     ok;
        longint ec;
        int     ect;
        bo_start(c, ok);
        if (ok) begin
            m_byteout(c, ec, ect);
            bo_finish(ec, ect);
        end
    endtask

    task automatic fl_start(input logic [27:0] c, input logic [15:0] a, input logic [3:0] ct,
                            output bit ok);
        flush_req = 1'b1;
        c_in = c; a_in = a; ct_in = ct;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL fl_accept: req_ready never seen for flush");
            flush_req = 1'b0;
        end
    endtask

    task automatic fl_finish();
        int pulses = 0;
        int last = -1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (flush_done) begin pulses++; last = i; end
            if (last >= 0 && i >= last + 3) break;
        end
        chk("flush_done_pulses", pulses, 1);
        chk("flush_byte_count", byte_count, m_cnt % 65536);
        @(posedge clk); #1;
    endtask

    task automatic fl_model(input logic [27:0] c, input logic [15:0] a, input logic [3:0] ct);
        bit ok;
        fl_start(c, a, ct, ok);
        if (ok) begin
            m_flush(c, a, ct);
            fl_finish();
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", out_valid, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_byte_count"}, byte_count, 0);
        chk({tag, "_c_out"}, c_out, 0);
        chk({tag, "_ct_out"}, ct_out, 0);
        chk({tag, "_bo_done"}, bo_done, 0);
        chk({tag, "_flush_done"}, flush_done, 0);
        chk({tag, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: every accepted FIFO head must match the next expected {byte, address}.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_byte: got 0x%0h at bp 0x%0h, none expected",
                             out_data, out_bp);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.byte_v);
                    chk("out_bp", out_bp, e.bp);
                end
            end
        end
    end

    initial begin
        bit ok;
        int fd;

        tbl[0] = '{28'h0180000, 8'h00, 28'h0000000, 8};
        tbl[1] = '{28'h0A00000, 8'h03, 28'h0000000, 8};
        tbl[2] = '{28'h0180000, 8'h14, 28'h0000000, 8};
        tbl[3] = '{28'h8080000, 8'h04, 28'h0000000, 8};
        tbl[4] = '{28'h7F81234, 8'h01, 28'h0001234, 8};
        tbl[5] = '{28'h0345678, 8'hFF, 28'h0045678, 7};
        tbl[6] = '{28'h7F00000, 8'h03, 28'h0000000, 8};
        tbl[7] = '{28'h8100000, 8'hFF, 28'h0000000, 7};
        tbl[8] = '{28'h0000000, 8'h01, 28'h0000000, 8};

        @(posedge clk); #1;
        chk_reset_outputs("rst0");
        #6 rst = 1'b1;
        @(posedge clk); #1;

        ready_mode = 1;
        for (int i = 0; i < 9; i++) begin
            bo_start(28'(tbl[i].c), ok);
            if (ok) begin
                m_emit(tbl[i].emit);
                bo_finish(tbl[i].ec, tbl[i].ect);
            end
        end
        m_b = 0;
        wait_drain();

        // Backpressure: fill the FIFO, then hold a request that must wait.
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < DEPTH; i++) bo_model(28'($urandom) & 28'h7FFFFFF);
        bo_req = 1'b1;
        c_in = 28'h0280000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("req_ready_full", req_ready, 0);
            chk("head_stable", out_data, exp_q[0].byte_v);
            @(posedge clk); #1;
        end
        ready_mode = 1;
        bo_model(28'h0280000);
        wait_drain();

        // Flush whose final byte is 0xFF (dropped), then one whose final byte 0x0F is kept.
        bo_model(28'h0A80000);
        fl_start(28'h0000000, 16'h0000, 4'd11, ok);
        if (ok) begin
            m_emit(8'h15); m_emit(8'h7F);
            m_first = 1'b1; m_b = 0;
            fl_finish();
        end
        wait_drain();
        bo_model(28'h0A80000);
        fl_start(28'h0000000, 16'h0000, 4'd0, ok);
        if (ok) begin
            m_emit(8'h15); m_emit(8'h00); m_emit(8'h0F);
            m_first = 1'b1; m_b = 0;
            fl_finish();
        end
        wait_drain();

        // bo_req and flush_req together: only the BYTEOUT happens.
        flush_req = 1'b1;
        bo_model(28'h0A80000);
        fd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (flush_done) fd++;
        end
        chk("no_flush_with_bo", fd, 0);
        @(posedge clk); #1;

        // Reset while bytes sit in the FIFO.
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        bo_model(28'h0100000);
        bo_model(28'h0100000);
        chk("pre_reset_valid", out_valid, 1);
        #3 rst = 1'b0;
        #1;
        chk_reset_outputs("rst1");
        exp_q.delete();
        m_first = 1'b1; m_b = 0; m_bp = 0; m_cnt = 0;
        ready_mode = 1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        bo_model(28'h0A80000);
        bo_model(28'h0100000);
        wait_drain();

        // Random traffic with random consumer stalls.
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 17)      bo_model(28'($urandom));
            else if (r < 19) fl_model(28'($urandom), 16'($urandom), 4'($urandom));
            else begin @(posedge clk); #1; end
        end
        ready_mode = 1;
        repeat (2) begin @(posedge clk); #1; end
        wait_drain();
        chk("final_byte_count", byte_count, m_cnt % 65536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mq_byteout_buf.md
Name: mq_byteout_buf

Overview:
- MQ arithmetic-coder byte-output stage: executes the BYTEOUT procedure on the 28-bit code register C.
- Holds the current byte B internally so a later carry can still modify it.
- Applies 0xFF bit stuffing and emits finished bytes with a buffer pointer through a parametrised FIFO with valid/ready handshake.
- Performs the complete FLUSH sequence (SETBITS, two BYTEOUTs, final-byte rule); sits between the renormalisation unit and the codestream writer.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
BP_W, 16, width of byte pointer / address
BP_START, 0, address of first emitted byte

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
bo_req  in  1  BYTEOUT request (renorm CT reached 0)
flush_req  in  1  start FLUSH sequence
req_ready  out  1  request accepted this cycle if asserted
c_in  in  28  code register C at request
a_in  in  16  interval register A (used by flush only)
ct_in  in  4  current CT (used by flush only)
c_out  out  28  updated C
ct_out  out  4  reloaded CT (7 or 8)
bo_done  out  1  one-cycle pulse: c_out/ct_out valid
flush_done  out  1  one-cycle pulse: flush complete, all bytes queued
out_data  out  8  emitted byte
out_bp  out  BP_W  address of out_data
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
byte_count  out  BP_W  total bytes queued since reset

Behaviour:
- Reset (rst=0, async): out_valid=0, FIFO empty, B=0x00, first=1, bp=BP_START, c_out=0, ct_out=0, bo_done=0, flush_done=0, byte_count=0, state=IDLE.
- req_ready = (state==IDLE) and (FIFO free entries >= 1); flush additionally needs >= 2 free entries.
- bo_req and flush_req together: flush_req ignored, bo_req served.
- BYTEOUT, registered on an accepted bo_req; c_out/ct_out/bo_done appear the next cycle (latency 1).
- Case B==0xFF: emit B; B = C[26:20]; C &= 0xFFFFF; CT = 7.
- Case C < 0x8000000: emit B; B = C[26:19]; C &= 0x7FFFF; CT = 8.
- Otherwise (carry): B = B+1.
  - If the new B == 0xFF: C &= 0x7FFFFFF; emit B; B = C[26:20]; C &= 0xFFFFF; CT = 7.
  - Else: emit B; B = C[26:19] (bit 27 discarded); C &= 0x7FFFF; CT = 8.
- B+1 never overflows, because the carry case is only reached with B != 0xFF.
- "Emit" pushes {B, bp} into the FIFO, then bp++ and byte_count++.
- While first==1, emit is suppressed (dummy byte at BP_START-1) and first is cleared; bp is not incremented.
- FLUSH states: IDLE -> SETB -> FL1 -> FL2 -> LAST -> IDLE, one cycle each.
- SETB: T = C + A (28-bit); C |= 0xFFFF; if C >= T then C -= 0x8000; then C = (C << CT) masked to 28 bits.
- FL1: BYTEOUT on C, then C <<= CT_new (masked to 28 bits).
- FL2: BYTEOUT on C, then C <<= CT_new (masked to 28 bits).
- LAST: if B != 0xFF, emit B; if B == 0xFF, discard it. flush_done pulses in LAST; first is reset to 1 for the next codeblock; bp keeps counting.
- Flush stalls in any state only if the FIFO is full at an emit (out_ready=0); the push happens when space frees.
- FIFO: push and pop in the same cycle are allowed when full. out_data/out_bp are stable while out_valid=1 and out_ready=0. No data loss, no duplicate pop.
- bp wraps modulo 2^BP_W silently.

Test Plan:
1. Reset mid-stream (rst low while out_valid=1) -> all outputs zero next edge, bp=BP_START, FIFO empty, first=1.
2. bo_req c_in=0x0180000 then bo_req c_in=0x0A00000 -> first: nothing emitted, c_out=0, ct_out=8; second: out_data=0x03, out_bp=0, ct_out=8, B=0x14.
3. Carry: held B=0x03, c_in=0x8080000 -> emits 0x04, new B=0x01, c_out=0x00000, ct_out=8.
4. Stuffing: held B=0xFF, c_in=0x0300000 -> emits 0xFF, B=0x03, c_out=0, ct_out=7. Carry into 0xFE with c_in=0x8100000 -> emits 0xFF, B=0x01, ct_out=7.
5. Backpressure: out_ready=0, issue FIFO_DEPTH+1 emitting requests -> req_ready drops after FIFO_DEPTH pushes; FIFO order and out_bp preserved once out_ready=1.
6. Flush ending with B=0xFF -> final 0xFF not queued; flush ending with B=0x5A -> 0x5A queued. flush_done pulses once, byte_count matches the number of emitted bytes.
